// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and the opcode encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_NOT = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between an ALU requester (master) and the ALU (slave).
interface alu_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  import alu_pkg::*;

  logic             in_valid;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  alu_op_e          opcode;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             carry;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, operand_a, operand_b, opcode,
    input  result, out_valid, carry, zero, overflow
  );

  modport slave (
    input  in_valid, operand_a, operand_b, opcode,
    output result, out_valid, carry, zero, overflow
  );

endinterface

// File: rtl/alu_datapath.sv
// Purely combinational ALU core: next result, carry/borrow/shift-out and
// signed overflow for the selected opcode.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit catches carry-out on add and borrow on subtract.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (op)
      OP_ADD: begin
        y        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y        = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y     = {a[WIDTH-2:0], 1'b0};
        carry = a[WIDTH-1];
      end
      OP_SHR: begin
        y     = {1'b0, a[WIDTH-1:1]};
        carry = a[0];
      end
      OP_NOT: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, outputs hold while no input is valid.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] dp_result;
  logic             dp_carry;
  logic             dp_overflow;

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;

  alu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .a        (bus.operand_a),
    .b        (bus.operand_b),
    .op       (bus.opcode),
    .y        (dp_result),
    .carry    (dp_carry),
    .overflow (dp_overflow)
  );

  // Capture only on in_valid so junk operands on idle cycles never reach the outputs.
  always_comb begin
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    valid_d    = bus.in_valid;
    if (bus.in_valid) begin
      result_d   = dp_result;
      carry_d    = dp_carry;
      overflow_d = dp_overflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = valid_q;
  assign bus.zero      = (result_q == '0);

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the WIDTH=4 registered ALU.
module tb_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    alu_op_e    op;
    logic [3:0] r;
    logic       c;
    logic       o;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_if #(.WIDTH(4)) bus ();

  alu #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, let the next rising edge sample them, look 1 ns later.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input alu_op_e op, input logic v);
    bus.in_valid  = v;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.opcode    = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.operand_a = 4'b0111;
    bus.operand_b = 4'b0001;
    bus.opcode    = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow} !== {1'b0, 4'b0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b c=%b z=%b o=%b want v=0 r=0000 c=0 z=1 o=0",
               bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow);
    end
    #3 rst = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_ops();
    vec_t v [8];
    // a=1010 (-6), b=0011 (3): SUB gives -9, outside the 4-bit signed range.
    v[0] = '{4'b1010, 4'b0011, OP_ADD, 4'b1101, 1'b0, 1'b0};
    v[1] = '{4'b1010, 4'b0011, OP_SUB, 4'b0111, 1'b0, 1'b1};
    v[2] = '{4'b1010, 4'b0011, OP_AND, 4'b0010, 1'b0, 1'b0};
    v[3] = '{4'b1010, 4'b0011, OP_OR,  4'b1011, 1'b0, 1'b0};
    v[4] = '{4'b1010, 4'b0011, OP_XOR, 4'b1001, 1'b0, 1'b0};
    v[5] = '{4'b1010, 4'b0000, OP_SHL, 4'b0100, 1'b1, 1'b0};
    v[6] = '{4'b1010, 4'b0000, OP_SHR, 4'b0101, 1'b0, 1'b0};
    v[7] = '{4'b1010, 4'b0000, OP_NOT, 4'b0101, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      issue(v[i].a, v[i].b, v[i].op, 1'b1);
      n_checks++;
      if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow} !==
          {1'b1, v[i].r, v[i].c, (v[i].r == 4'b0000), v[i].o}) begin
        n_fail++;
        $display("FAIL ops[%0d] op=%s: got v=%b r=%b c=%b z=%b o=%b want v=1 r=%b c=%b z=%b o=%b",
                 i, v[i].op.name(), bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow,
                 v[i].r, v[i].c, (v[i].r == 4'b0000), v[i].o);
      end
    end
  endtask

  task automatic test_boundaries();
    vec_t v [6];
    v[0] = '{4'b1111, 4'b0001, OP_ADD, 4'b0000, 1'b1, 1'b0};
    v[1] = '{4'b0111, 4'b0001, OP_ADD, 4'b1000, 1'b0, 1'b1};
    v[2] = '{4'b0011, 4'b0101, OP_SUB, 4'b1110, 1'b1, 1'b0};
    v[3] = '{4'b1000, 4'b0001, OP_SUB, 4'b0111, 1'b0, 1'b1};
    v[4] = '{4'b0101, 4'b0101, OP_SUB, 4'b0000, 1'b0, 1'b0};
    v[5] = '{4'b1000, 4'b1111, OP_SHL, 4'b0000, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue(v[i].a, v[i].b, v[i].op, 1'b1);
      n_checks++;
      if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow} !==
          {1'b1, v[i].r, v[i].c, (v[i].r == 4'b0000), v[i].o}) begin
        n_fail++;
        $display("FAIL boundary[%0d] op=%s: got v=%b r=%b c=%b z=%b o=%b want v=1 r=%b c=%b z=%b o=%b",
                 i, v[i].op.name(), bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow,
                 v[i].r, v[i].c, (v[i].r == 4'b0000), v[i].o);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [3];
    v[0] = '{4'b0001, 4'b0010, OP_ADD, 4'b0011, 1'b0, 1'b0};
    v[1] = '{4'b0101, 4'b0001, OP_SUB, 4'b0100, 1'b0, 1'b0};
    v[2] = '{4'b0011, 4'b1111, OP_SHR, 4'b0001, 1'b1, 1'b0};
    issue(4'b0000, 4'b0000, OP_ADD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      issue(v[i].a, v[i].b, v[i].op, 1'b1);
      n_checks++;
      if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow} !==
          {1'b1, v[i].r, v[i].c, 1'b0, v[i].o}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b r=%b c=%b z=%b o=%b want v=1 r=%b c=%b z=0 o=%b",
                 i, bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow, v[i].r, v[i].c, v[i].o);
      end
    end
    for (int i = 0; i < 2; i++) begin
      issue(4'b1111, 4'b1111, OP_ADD, 1'b0);
      n_checks++;
      if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow} !== {1'b0, 4'b0001, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stream_hold[%0d]: got v=%b r=%b c=%b z=%b o=%b want v=0 r=0001 c=1 z=0 o=0",
                 i, bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow);
      end
    end
  endtask

  task automatic test_idle_x();
    issue(4'b0111, 4'b0001, OP_ADD, 1'b1);
    n_checks++;
    if ({bus.out_valid, bus.result, bus.overflow} !== {1'b1, 4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL idle_setup: got v=%b r=%b o=%b want v=1 r=1000 o=1", bus.out_valid, bus.result, bus.overflow);
    end
    for (int i = 0; i < 2; i++) begin
      issue(4'bxxxx, 4'bxxxx, OP_SUB, 1'b0);
      n_checks++;
      if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow} !== {1'b0, 4'b1000, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL idle_x_hold[%0d]: got v=%b r=%b c=%b z=%b o=%b want v=0 r=1000 c=0 z=0 o=1",
                 i, bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow);
      end
    end
  endtask

  task automatic test_async_reset();
    issue(4'b1111, 4'b0001, OP_ADD, 1'b1);
    issue(4'b1001, 4'b1001, OP_ADD, 1'b1);
    n_checks++;
    if ({bus.out_valid, bus.result, bus.carry, bus.overflow} !== {1'b1, 4'b0010, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_setup: got v=%b r=%b c=%b o=%b want v=1 r=0010 c=1 o=1",
               bus.out_valid, bus.result, bus.carry, bus.overflow);
    end
    // Mid-cycle assertion: outputs must clear with no clock edge involved.
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow} !== {1'b0, 4'b0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_immediate: got v=%b r=%b c=%b z=%b o=%b want v=0 r=0000 c=0 z=1 o=0",
               bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.result, bus.zero} !== {1'b0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_held: got v=%b r=%b z=%b want v=0 r=0000 z=1", bus.out_valid, bus.result, bus.zero);
    end
    #3 rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.result, bus.zero} !== {1'b0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_idle: got v=%b r=%b z=%b want v=0 r=0000 z=1", bus.out_valid, bus.result, bus.zero);
    end
    issue(4'b1100, 4'b0110, OP_AND, 1'b1);
    n_checks++;
    if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow} !== {1'b1, 4'b0100, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_resume: got v=%b r=%b c=%b z=%b o=%b want v=1 r=0100 c=0 z=0 o=0",
               bus.out_valid, bus.result, bus.carry, bus.zero, bus.overflow);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.operand_a = 4'b0000;
    bus.operand_b = 4'b0000;
    bus.opcode    = OP_ADD;
    #1;
    test_reset();
    test_ops();
    test_boundaries();
    test_back_to_back();
    test_idle_x();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
